// File: rtl/dsp_nco_sweep.sv
// Frequency-sweep (chirp) controller driving dsp_nco phi_inc/en.
// Steps the tuning word from f_start to f_stop in single-ramp, sawtooth or triangle mode.
module dsp_nco_sweep #(
    parameter int PHI_WIDTH   = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [1:0]             mode,
    input  logic [PHI_WIDTH-1:0]   f_start,
    input  logic [PHI_WIDTH-1:0]   f_stop,
    input  logic [PHI_WIDTH-1:0]   f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [PHI_WIDTH-1:0]   phi_inc,
    output logic                   nco_en,
    output logic                   busy,
    output logic                   sweep_end,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                 state, state_nx;
    logic [1:0]             cfg_mode;
    logic [PHI_WIDTH-1:0]   cfg_start, cfg_stop, cfg_step;
    logic [DWELL_WIDTH-1:0] cfg_dwell, dwell_cnt, dwell_cnt_nx;
    logic                   cfg_load;

    logic [PHI_WIDTH-1:0]   phi_nx;
    logic                   nco_en_nx, busy_nx, sweep_end_nx, done_nx, err_nx;

    logic [PHI_WIDTH:0]     up_sum;
    logic signed [PHI_WIDTH:0] dn_diff;
    logic [PHI_WIDTH-1:0]   up_next, dn_next;
    logic                   expired;

    // One extra bit keeps overflow/underflow visible so both clamp to the endpoint.
    assign up_sum  = {1'b0, phi_inc} + {1'b0, cfg_step};
    assign dn_diff = $signed({1'b0, phi_inc}) - $signed({1'b0, cfg_step});
    assign up_next = (up_sum > {1'b0, cfg_stop}) ? cfg_stop : up_sum[PHI_WIDTH-1:0];
    assign dn_next = (dn_diff < $signed({1'b0, cfg_start})) ? cfg_start : dn_diff[PHI_WIDTH-1:0];
    assign expired = (dwell_cnt == cfg_dwell);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_nx     = state;
        phi_nx       = phi_inc;
        nco_en_nx    = nco_en;
        busy_nx      = busy;
        dwell_cnt_nx = dwell_cnt;
        sweep_end_nx = 1'b0;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        cfg_load     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (f_step == '0 || f_stop < f_start) begin
                        err_nx = 1'b1;
                    end else begin
                        cfg_load     = 1'b1;
                        phi_nx       = f_start;
                        nco_en_nx    = 1'b1;
                        busy_nx      = 1'b1;
                        dwell_cnt_nx = '0;
                        state_nx     = UP;
                    end
                end
            end
            UP: begin
                if (expired) begin
                    dwell_cnt_nx = '0;
                    if (phi_inc == cfg_stop) begin
                        sweep_end_nx = 1'b1;
                        case (cfg_mode)
                            2'd1: phi_nx = cfg_start;
                            2'd2: begin
                                state_nx = DOWN;
                                phi_nx   = dn_next;
                            end
                            default: begin
                                state_nx  = IDLE;
                                nco_en_nx = 1'b0;
                                busy_nx   = 1'b0;
                                done_nx   = 1'b1;
                            end
                        endcase
                    end else begin
                        phi_nx = up_next;
                    end
                end else begin
                    dwell_cnt_nx = dwell_cnt + 1'b1;
                end
            end
            DOWN: begin
                if (expired) begin
                    dwell_cnt_nx = '0;
                    if (phi_inc == cfg_start) begin
                        state_nx     = UP;
                        sweep_end_nx = 1'b1;
                        phi_nx       = up_next;
                    end else begin
                        phi_nx = dn_next;
                    end
                end else begin
                    dwell_cnt_nx = dwell_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort wins over everything, including a start in the same cycle.
        if (abort) begin
            state_nx     = IDLE;
            phi_nx       = phi_inc;
            nco_en_nx    = 1'b0;
            busy_nx      = 1'b0;
            dwell_cnt_nx = '0;
            sweep_end_nx = 1'b0;
            done_nx      = 1'b0;
            err_nx       = 1'b0;
            cfg_load     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state     <= IDLE;
            phi_inc   <= '0;
            nco_en    <= 1'b0;
            busy      <= 1'b0;
            sweep_end <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            dwell_cnt <= '0;
            cfg_mode  <= '0;
            cfg_start <= '0;
            cfg_stop  <= '0;
            cfg_step  <= '0;
            cfg_dwell <= '0;
        end else begin
            state     <= state_nx;
            phi_inc   <= phi_nx;
            nco_en    <= nco_en_nx;
            busy      <= busy_nx;
            sweep_end <= sweep_end_nx;
            done      <= done_nx;
            err       <= err_nx;
            dwell_cnt <= dwell_cnt_nx;
            if (cfg_load) begin
                cfg_mode  <= mode;
                cfg_start <= f_start;
                cfg_stop  <= f_stop;
                cfg_step  <= f_step;
                cfg_dwell <= dwell;
            end
        end
    end

endmodule

// File: tb/tb_dsp_nco_sweep.sv
// Directed bench for dsp_nco_sweep: expected outputs are queued with each stimulus step
// and popped/compared one edge later. A second 8-bit instance covers tuning-word overflow.
module tb_dsp_nco_sweep;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [1:0]  mode;
    logic [31:0] f_start, f_stop, f_step, phi_inc;
    logic [15:0] dwell;
    logic        nco_en, busy, sweep_end, done, err;

    logic        start8, abort8;
    logic [1:0]  mode8;
    logic [7:0]  f_start8, f_stop8, f_step8, phi_inc8;
    logic [15:0] dwell8;
    logic        nco_en8, busy8, sweep_end8, done8, err8;

    always #5 clk = ~clk;

    dsp_nco_sweep #(.PHI_WIDTH(32), .DWELL_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
        .phi_inc(phi_inc), .nco_en(nco_en), .busy(busy),
        .sweep_end(sweep_end), .done(done), .err(err)
    );

    dsp_nco_sweep #(.PHI_WIDTH(8), .DWELL_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(abort8), .mode(mode8),
        .f_start(f_start8), .f_stop(f_stop8), .f_step(f_step8), .dwell(dwell8),
        .phi_inc(phi_inc8), .nco_en(nco_en8), .busy(busy8),
        .sweep_end(sweep_end8), .done(done8), .err(err8)
    );

    typedef struct packed {
        logic [31:0] phi;
        logic        en;
        logic        busy;
        logic        se;
        logic        done;
        logic        err;
    } obs_t;

    obs_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Queue the outputs expected after the coming edge, clock it, then compare.
    task automatic cyc(input string tag, input logic [31:0] phi, input logic en, input logic bz,
                       input logic se, input logic dn, input logic er, input bit use8 = 1'b0);
        obs_t e, o;
        exp_q.push_back('{phi, en, bz, se, dn, er});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (use8) o = '{{24'd0, phi_inc8}, nco_en8, busy8, sweep_end8, done8, err8};
        else      o = '{phi_inc, nco_en, busy, sweep_end, done, err};
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed phi=%0d en=%b busy=%b end=%b done=%b err=%b, expected phi=%0d en=%b busy=%b end=%b done=%b err=%b",
                   tag, o.phi, o.en, o.busy, o.se, o.done, o.err, e.phi, e.en, e.busy, e.se, e.done, e.err);
        end
    endtask

    task automatic act(input string tag, input logic [31:0] phi, input logic se = 1'b0);
        cyc(tag, phi, 1'b1, 1'b1, se, 1'b0, 1'b0);
    endtask

    task automatic idle(input string tag, input logic [31:0] phi);
        cyc(tag, phi, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic fin(input string tag, input logic [31:0] phi);
        cyc(tag, phi, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic cfg(input logic [1:0] m, input logic [31:0] fs, input logic [31:0] fe,
                       input logic [31:0] st, input logic [15:0] dw);
        mode = m; f_start = fs; f_stop = fe; f_step = st; dwell = dw;
    endtask

    initial begin
        int unsigned t1_seq[11];
        t1_seq = '{100, 100, 110, 110, 110, 120, 120, 120, 130, 130, 130};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg(2'd0, 32'd0, 32'd0, 32'd0, 16'd0);
        start8 = 1'b0; abort8 = 1'b0; mode8 = 2'd0;
        f_start8 = 8'd0; f_stop8 = 8'd0; f_step8 = 8'd0; dwell8 = 16'd0;

        idle("reset0", 0);
        idle("reset1", 0);
        rst = 1'b0;
        idle("idle_after_reset", 0);

        // Single ramp with dwell 2: each word held three cycles, 12 enabled cycles in all.
        cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd2);
        start = 1'b1;
        act("t1_accept", 100);
        start = 1'b0;
        foreach (t1_seq[i]) act($sformatf("t1_ramp%0d", i), t1_seq[i]);
        fin("t1_done", 130);
        idle("t1_idle", 130);

        // Clamp to f_stop; config changes mid-sweep must be ignored.
        cfg(2'd0, 32'd100, 32'd125, 32'd10, 16'd0);
        start = 1'b1;
        act("t2_accept", 100);
        start = 1'b0;
        cfg(2'd1, 32'd0, 32'd500, 32'd1, 16'd5);
        act("t2_110", 110);
        act("t2_120", 120);
        act("t2_clamp", 125);
        fin("t2_done", 125);
        idle("t2_idle", 125);

        // 8-bit tuning word: 250+10 overflows and must clamp to 255, not wrap.
        f_start8 = 8'd250; f_stop8 = 8'd255; f_step8 = 8'd10; dwell8 = 16'd0; mode8 = 2'd0;
        start8 = 1'b1;
        cyc("t2b_accept", 250, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        start8 = 1'b0;
        cyc("t2b_clamp", 255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("t2b_done", 255, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("t2b_idle", 255, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Triangle 0..20 step 10, then abort mid-sweep.
        cfg(2'd2, 32'd0, 32'd20, 32'd10, 16'd0);
        start = 1'b1;
        act("t3_accept", 0);
        start = 1'b0;
        act("t3_10a", 10);
        act("t3_20a", 20);
        act("t3_down10", 10, 1'b1);
        act("t3_0", 0);
        act("t3_up10", 10, 1'b1);
        act("t3_20b", 20);
        act("t3_down10b", 10, 1'b1);
        abort = 1'b1;
        idle("t6_abort", 10);
        abort = 1'b0;
        idle("t6_abort_idle", 10);

        // Sawtooth 5..7 step 1 dwell 1; start while busy is ignored; abort+start drops the start.
        cfg(2'd1, 32'd5, 32'd7, 32'd1, 16'd1);
        start = 1'b1;
        act("t4_accept", 5);
        start = 1'b0;
        act("t4_5", 5);
        act("t4_6a", 6);
        act("t4_6b", 6);
        act("t4_7a", 7);
        act("t4_7b", 7);
        act("t4_wrap", 5, 1'b1);
        act("t4_5b", 5);
        cfg(2'd0, 32'd60, 32'd70, 32'd1, 16'd0);
        start = 1'b1;
        act("t6_busy_start_a", 6);
        act("t6_busy_start_b", 6);
        abort = 1'b1;
        idle("t6_abort_start_busy", 6);
        idle("t6_abort_start_idle", 6);
        abort = 1'b0; start = 1'b0;
        idle("t6_start_dropped", 6);

        // Rejected starts: zero step, then f_stop < f_start.
        cfg(2'd0, 32'd50, 32'd60, 32'd0, 16'd0);
        start = 1'b1;
        cyc("t5_step0_err", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        idle("t5_step0_after", 6);
        cfg(2'd0, 32'd50, 32'd40, 32'd5, 16'd0);
        start = 1'b1;
        cyc("t5_order_err", 6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        start = 1'b0;
        idle("t5_order_after", 6);

        // f_start == f_stop in triangle: constant word, sweep_end every turn.
        cfg(2'd2, 32'd40, 32'd40, 32'd1, 16'd0);
        start = 1'b1;
        act("eq_accept", 40);
        start = 1'b0;
        act("eq_turn_down", 40, 1'b1);
        act("eq_turn_up", 40, 1'b1);
        abort = 1'b1;
        idle("eq_abort", 40);
        abort = 1'b0;

        // Reserved mode 3 behaves as single ramp.
        cfg(2'd3, 32'd40, 32'd40, 32'd1, 16'd1);
        start = 1'b1;
        act("m3_accept", 40);
        start = 1'b0;
        act("m3_hold", 40);
        fin("m3_done", 40);

        // Synchronous reset mid-sweep overrides a concurrent start.
        cfg(2'd0, 32'd100, 32'd130, 32'd10, 16'd2);
        start = 1'b1;
        act("t6r_accept", 100);
        start = 1'b0;
        act("t6r_hold", 100);
        rst = 1'b1; start = 1'b1;
        idle("t6r_reset", 0);
        rst = 1'b0; start = 1'b0;
        idle("t6r_idle", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
